alu_reservation_station: RTL and testbench

Reservation station directly upstream of the ALU in the out-of-order core. Holds dispatched ALU instructions until both operands are available, snooping the ALU and LSB result broadcasts for missing operands. Each cycle it issues at most one ready instruction to the ALU, using the ALU's input signal set. Branch mispredict flushes every entry.

---
 rtl/alu_reservation_station.sv | 217 +++++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// Reservation station in front of the ALU: buffers dispatched ops until both operands
// arrive via the ALU/LSB broadcast buses, then issues the lowest-index ready entry per cycle.
module alu_reservation_station #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             disp_valid,
    input  logic [TAG_W-1:0] disp_ins_id,
    input  logic [6:0]       disp_opcode,
    input  logic [2:0]       disp_funct3,
    input  logic [6:0]       disp_funct7,
    input  logic [31:0]      disp_imm,
    input  logic             disp_rs1_rdy,
    input  logic [31:0]      disp_rs1_val,
    input  logic [TAG_W-1:0] disp_rs1_tag,
    input  logic             disp_rs2_rdy,
    input  logic [31:0]      disp_rs2_val,
    input  logic [TAG_W-1:0] disp_rs2_tag,
    input  logic             alu_cdb_valid,
    input  logic [TAG_W-1:0] alu_cdb_id,
    input  logic [31:0]      alu_cdb_val,
    input  logic             lsb_cdb_valid,
    input  logic [TAG_W-1:0] lsb_cdb_id,
    input  logic [31:0]      lsb_cdb_val,
    output logic             rs_full,
    output logic             have_ins,
    output logic [TAG_W-1:0] ins_id,
    output logic [31:0]      rs1_val,
    output logic [31:0]      rs2_val,
    output logic [31:0]      imm_val,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] e_rdy1_q, e_rdy1_d, e_rdy2_q, e_rdy2_d;
    logic [TAG_W-1:0] e_id_q   [DEPTH];
    logic [TAG_W-1:0] e_id_d   [DEPTH];
    logic [6:0]       e_op_q   [DEPTH];
    logic [6:0]       e_op_d   [DEPTH];
    logic [2:0]       e_f3_q   [DEPTH];
    logic [2:0]       e_f3_d   [DEPTH];
    logic [6:0]       e_f7_q   [DEPTH];
    logic [6:0]       e_f7_d   [DEPTH];
    logic [31:0]      e_imm_q  [DEPTH];
    logic [31:0]      e_imm_d  [DEPTH];
    logic [31:0]      e_val1_q [DEPTH];
    logic [31:0]      e_val1_d [DEPTH];
    logic [31:0]      e_val2_q [DEPTH];
    logic [31:0]      e_val2_d [DEPTH];
    logic [TAG_W-1:0] e_tag1_q [DEPTH];
    logic [TAG_W-1:0] e_tag1_d [DEPTH];
    logic [TAG_W-1:0] e_tag2_q [DEPTH];
    logic [TAG_W-1:0] e_tag2_d [DEPTH];

    logic             have_ins_q, have_ins_d;
    logic [TAG_W-1:0] ins_id_q, ins_id_d;
    logic [31:0]      rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d, imm_val_q, imm_val_d;
    logic [6:0]       opcode_q, opcode_d, funct7_q, funct7_d;
    logic [2:0]       funct3_q, funct3_d;

    logic             issue_ok;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] free_idx;
    logic             disp_ok;

    // Operand capture from the broadcast buses; the ALU bus takes priority.
    function automatic logic [32:0] snoop(input logic rdy, input logic [31:0] val,
                                          input logic [TAG_W-1:0] tag);
        if (rdy)
            return {1'b1, val};
        if (alu_cdb_valid && alu_cdb_id == tag)
            return {1'b1, alu_cdb_val};
        if (lsb_cdb_valid && lsb_cdb_id == tag)
            return {1'b1, lsb_cdb_val};
        return {1'b0, val};
    endfunction

    // Eligibility uses only registered state, so a wakeup takes effect one cycle later.
    always_comb begin
        issue_ok  = 1'b0;
        issue_idx = '0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (busy_q[i] && e_rdy1_q[i] && e_rdy2_q[i]) begin
                issue_ok  = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!busy_q[i])
                free_idx = IDX_W'(i);
        end
    end

    assign rs_full = &busy_q;
    assign disp_ok = disp_valid && !rs_full;

    always_comb begin
        busy_d   = busy_q;
        e_rdy1_d = e_rdy1_q;
        e_rdy2_d = e_rdy2_q;
        e_id_d   = e_id_q;
        e_op_d   = e_op_q;
        e_f3_d   = e_f3_q;
        e_f7_d   = e_f7_q;
        e_imm_d  = e_imm_q;
        e_val1_d = e_val1_q;
        e_val2_d = e_val2_q;
        e_tag1_d = e_tag1_q;
        e_tag2_d = e_tag2_q;
        if (rdy_in) begin
            if (flush) begin
                busy_d = '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy_q[i]) begin
                        {e_rdy1_d[i], e_val1_d[i]} = snoop(e_rdy1_q[i], e_val1_q[i], e_tag1_q[i]);
                        {e_rdy2_d[i], e_val2_d[i]} = snoop(e_rdy2_q[i], e_val2_q[i], e_tag2_q[i]);
                    end
                end
                if (issue_ok)
                    busy_d[issue_idx] = 1'b0;
                // free_idx comes from pre-edge state, so it never aliases the issuing slot.
                if (disp_ok) begin
                    busy_d[free_idx]   = 1'b1;
                    e_id_d[free_idx]   = disp_ins_id;
                    e_op_d[free_idx]   = disp_opcode;
                    e_f3_d[free_idx]   = disp_funct3;
                    e_f7_d[free_idx]   = disp_funct7;
                    e_imm_d[free_idx]  = disp_imm;
                    e_tag1_d[free_idx] = disp_rs1_tag;
                    e_tag2_d[free_idx] = disp_rs2_tag;
                    {e_rdy1_d[free_idx], e_val1_d[free_idx]} = snoop(disp_rs1_rdy, disp_rs1_val, disp_rs1_tag);
                    {e_rdy2_d[free_idx], e_val2_d[free_idx]} = snoop(disp_rs2_rdy, disp_rs2_val, disp_rs2_tag);
                end
            end
        end
    end

    always_comb begin
        have_ins_d = have_ins_q;
        ins_id_d   = ins_id_q;
        rs1_val_d  = rs1_val_q;
        rs2_val_d  = rs2_val_q;
        imm_val_d  = imm_val_q;
        opcode_d   = opcode_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        if (rdy_in) begin
            have_ins_d = 1'b0;
            if (!flush && issue_ok) begin
                have_ins_d = 1'b1;
                ins_id_d   = e_id_q[issue_idx];
                rs1_val_d  = e_val1_q[issue_idx];
                rs2_val_d  = e_val2_q[issue_idx];
                imm_val_d  = e_imm_q[issue_idx];
                opcode_d   = e_op_q[issue_idx];
                funct3_d   = e_f3_q[issue_idx];
                funct7_d   = e_f7_q[issue_idx];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q     <= '0;
            have_ins_q <= 1'b0;
            ins_id_q   <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_val_q  <= '0;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
        end else begin
            busy_q     <= busy_d;
            have_ins_q <= have_ins_d;
            ins_id_q   <= ins_id_d;
            rs1_val_q  <= rs1_val_d;
            rs2_val_q  <= rs2_val_d;
            imm_val_q  <= imm_val_d;
            opcode_q   <= opcode_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
        end
    end

    // Entry payload is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk_in) begin
        e_rdy1_q <= e_rdy1_d;
        e_rdy2_q <= e_rdy2_d;
        e_id_q   <= e_id_d;
        e_op_q   <= e_op_d;
        e_f3_q   <= e_f3_d;
        e_f7_q   <= e_f7_d;
        e_imm_q  <= e_imm_d;
        e_val1_q <= e_val1_d;
        e_val2_q <= e_val2_d;
        e_tag1_q <= e_tag1_d;
        e_tag2_q <= e_tag2_d;
    end

    assign have_ins = have_ins_q;
    assign ins_id   = ins_id_q;
    assign rs1_val  = rs1_val_q;
    assign rs2_val  = rs2_val_q;
    assign imm_val  = imm_val_q;
    assign opcode   = opcode_q;
    assign funct3   = funct3_q;
    assign funct7   = funct7_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: expected issues are queued at dispatch
// time and compared field by field whenever the station issues.
module tb_alu_reservation_station;
    localparam int DEPTH = 8;
    localparam int TAG_W = 5;

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in, flush, disp_valid;
    logic [TAG_W-1:0] disp_ins_id, disp_rs1_tag, disp_rs2_tag;
    logic [6:0]       disp_opcode, disp_funct7;
    logic [2:0]       disp_funct3;
    logic [31:0]      disp_imm, disp_rs1_val, disp_rs2_val;
    logic             disp_rs1_rdy, disp_rs2_rdy;
    logic             alu_cdb_valid, lsb_cdb_valid;
    logic [TAG_W-1:0] alu_cdb_id, lsb_cdb_id;
    logic [31:0]      alu_cdb_val, lsb_cdb_val;
    logic             rs_full, have_ins;
    logic [TAG_W-1:0] ins_id;
    logic [31:0]      rs1_val, rs2_val, imm_val;
    logic [6:0]       opcode, funct7;
    logic [2:0]       funct3;

    alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .disp_valid(disp_valid), .disp_ins_id(disp_ins_id), .disp_opcode(disp_opcode),
        .disp_funct3(disp_funct3), .disp_funct7(disp_funct7), .disp_imm(disp_imm),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val), .disp_rs1_tag(disp_rs1_tag),
        .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val), .disp_rs2_tag(disp_rs2_tag),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_id(alu_cdb_id), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_id(lsb_cdb_id), .lsb_cdb_val(lsb_cdb_val),
        .rs_full(rs_full), .have_ins(have_ins), .ins_id(ins_id),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm_val(imm_val),
        .opcode(opcode), .funct3(funct3), .funct7(funct7)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [TAG_W-1:0] id;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [31:0]      imm;
        logic [6:0]       op;
        logic [2:0]       f3;
        logic [6:0]       f7;
    } exp_t;

    exp_t             exp_q[$];
    int               n_chk = 0;
    int               n_err = 0;
    logic [TAG_W-1:0] last_id = '0;
    logic [31:0]      last_rs1 = '0;
    logic             rdy_at_edge = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [TAG_W-1:0] id, input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] imm, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7);
        exp_t e;
        e.id = id; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.op = op; e.f3 = f3; e.f7 = f7;
        exp_q.push_back(e);
    endtask

    task automatic dispatch(input logic [TAG_W-1:0] id, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm,
                            input logic r1r, input logic [31:0] r1v, input logic [TAG_W-1:0] r1t,
                            input logic r2r, input logic [31:0] r2v, input logic [TAG_W-1:0] r2t);
        disp_valid   = 1'b1;
        disp_ins_id  = id;
        disp_opcode  = op;
        disp_funct3  = f3;
        disp_funct7  = f7;
        disp_imm     = imm;
        disp_rs1_rdy = r1r;
        disp_rs1_val = r1v;
        disp_rs1_tag = r1t;
        disp_rs2_rdy = r2r;
        disp_rs2_val = r2v;
        disp_rs2_tag = r2t;
        @(posedge clk_in);
        #1;
        disp_valid = 1'b0;
    endtask

    task automatic bcast_alu(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        alu_cdb_valid = 1'b1; alu_cdb_id = tag; alu_cdb_val = val;
        @(posedge clk_in);
        #1;
        alu_cdb_valid = 1'b0;
    endtask

    task automatic bcast_lsb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        lsb_cdb_valid = 1'b1; lsb_cdb_id = tag; lsb_cdb_val = val;
        @(posedge clk_in);
        #1;
        lsb_cdb_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    always @(posedge clk_in) rdy_at_edge <= rdy_in;

    // Monitor: every fresh issue must match the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (rst_in && rdy_at_edge && have_ins) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_issue", 32'(have_ins), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ins_id", 32'(ins_id), 32'(e.id));
                    chk("rs1_val", rs1_val, e.rs1);
                    chk("rs2_val", rs2_val, e.rs2);
                    chk("imm_val", imm_val, e.imm);
                    chk("opcode", 32'(opcode), 32'(e.op));
                    chk("funct3", 32'(funct3), 32'(e.f3));
                    chk("funct7", 32'(funct7), 32'(e.f7));
                    last_id  = e.id;
                    last_rs1 = e.rs1;
                end
            end
        end
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; disp_valid = 1'b0;
        disp_ins_id = '0; disp_opcode = '0; disp_funct3 = '0; disp_funct7 = '0; disp_imm = '0;
        disp_rs1_rdy = 1'b0; disp_rs1_val = '0; disp_rs1_tag = '0;
        disp_rs2_rdy = 1'b0; disp_rs2_val = '0; disp_rs2_tag = '0;
        alu_cdb_valid = 1'b0; alu_cdb_id = '0; alu_cdb_val = '0;
        lsb_cdb_valid = 1'b0; lsb_cdb_id = '0; lsb_cdb_val = '0;
        #1 rst_in = 1'b0;
        #1;
        chk("rst_have_ins", 32'(have_ins), 32'd0);
        chk("rst_full", 32'(rs_full), 32'd0);
        chk("rst_ins_id", 32'(ins_id), 32'd0);
        chk("rst_rs1_val", rs1_val, 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst_in = 1'b1;

        // ADDI with rs1 ready: two-edge latency, single-cycle issue pulse
        push_exp(5'd4, 32'h10, 32'h0, 32'd5, 7'h13, 3'd0, 7'd0);
        dispatch(5'd4, 7'h13, 3'd0, 7'd0, 32'd5, 1'b1, 32'h10, 5'd0, 1'b1, 32'h0, 5'd0);
        @(negedge clk_in); chk("addi_lat", 32'(have_ins), 32'd0);
        @(negedge clk_in); chk("addi_issue", 32'(have_ins), 32'd1);
        @(negedge clk_in); chk("addi_done", 32'(have_ins), 32'd0);

        // ADD waiting on tag 3, woken by the ALU bus after a wrong-tag broadcast
        push_exp(5'd7, 32'h100, 32'hDEAD, 32'h0, 7'h33, 3'd0, 7'd0);
        dispatch(5'd7, 7'h33, 3'd0, 7'd0, 32'h0, 1'b1, 32'h100, 5'd0, 1'b0, 32'h0, 5'd3);
        bcast_alu(5'd2, 32'h2222);
        @(negedge clk_in); chk("add_wrong_tag", 32'(have_ins), 32'd0);
        bcast_alu(5'd3, 32'hDEAD);
        @(negedge clk_in); chk("add_wake_lat", 32'(have_ins), 32'd0);
        @(negedge clk_in); chk("add_issue", 32'(have_ins), 32'd1);

        // Dispatch-cycle bypass from the LSB bus
        push_exp(5'd8, 32'h200, 32'hBEEF, 32'h8, 7'h33, 3'd4, 7'd0);
        lsb_cdb_valid = 1'b1; lsb_cdb_id = 5'd3; lsb_cdb_val = 32'hBEEF;
        dispatch(5'd8, 7'h33, 3'd4, 7'd0, 32'h8, 1'b1, 32'h200, 5'd0, 1'b0, 32'h0, 5'd3);
        lsb_cdb_valid = 1'b0;
        @(negedge clk_in); chk("byp_lat", 32'(have_ins), 32'd0);
        @(negedge clk_in); chk("byp_issue", 32'(have_ins), 32'd1);

        // Fill all entries waiting on tag 9, overflow dispatch dropped, then drain in index order
        for (int i = 0; i < DEPTH; i++)
            dispatch(TAG_W'(10 + i), 7'h33, 3'(i), (i % 2 == 1) ? 7'h20 : 7'h00, 32'(i * 3),
                     1'b0, 32'h0, 5'd9, 1'b1, 32'(i + 100), 5'd0);
        @(negedge clk_in); chk("fill_full", 32'(rs_full), 32'd1);
        dispatch(5'd20, 7'h13, 3'd0, 7'd0, 32'h77, 1'b1, 32'h1, 5'd0, 1'b1, 32'h0, 5'd0);
        @(negedge clk_in); chk("drop_full", 32'(rs_full), 32'd1);
        for (int i = 0; i < DEPTH; i++)
            push_exp(TAG_W'(10 + i), 32'h99, 32'(i + 100), 32'(i * 3), 7'h33, 3'(i),
                     (i % 2 == 1) ? 7'h20 : 7'h00);
        bcast_lsb(5'd9, 32'h99);
        @(negedge clk_in); chk("drain_full_hold", 32'(rs_full), 32'd1);
        @(negedge clk_in); chk("drain_full_drop", 32'(rs_full), 32'd0);
        cycles(10);
        chk("fill_sb_empty", 32'(exp_q.size()), 32'd0);

        // Flush on the same cycle as the wakeup broadcast
        dispatch(5'd21, 7'h33, 3'd0, 7'd0, 32'h0, 1'b0, 32'h0, 5'd12, 1'b1, 32'h5, 5'd0);
        dispatch(5'd22, 7'h33, 3'd0, 7'd0, 32'h0, 1'b0, 32'h0, 5'd12, 1'b1, 32'h6, 5'd0);
        flush = 1'b1;
        alu_cdb_valid = 1'b1; alu_cdb_id = 5'd12; alu_cdb_val = 32'h1212;
        @(posedge clk_in);
        #1;
        flush = 1'b0; alu_cdb_valid = 1'b0;
        @(negedge clk_in);
        chk("flush_have_ins", 32'(have_ins), 32'd0);
        chk("flush_full", 32'(rs_full), 32'd0);
        cycles(4);
        for (int i = 0; i < DEPTH; i++) begin
            dispatch(TAG_W'(i), 7'h33, 3'd2, 7'd0, 32'(i), 1'b0, 32'h0, 5'd13, 1'b1, 32'(i), 5'd0);
            if (i == DEPTH - 2)
                chk("refill_not_full", 32'(rs_full), 32'd0);
        end
        chk("refill_full", 32'(rs_full), 32'd1);
        for (int i = 0; i < DEPTH; i++)
            push_exp(TAG_W'(i), 32'h1313, 32'(i), 32'(i), 7'h33, 3'd2, 7'd0);
        bcast_alu(5'd13, 32'h1313);
        cycles(12);
        chk("flush_sb_empty", 32'(exp_q.size()), 32'd0);

        // Stall with a ready entry pending and a live broadcast
        dispatch(5'd26, 7'h33, 3'd1, 7'd0, 32'h0, 1'b0, 32'h0, 5'd14, 1'b1, 32'h2, 5'd0);
        push_exp(5'd25, 32'h1, 32'h2, 32'h25, 7'h13, 3'd0, 7'd0);
        dispatch(5'd25, 7'h13, 3'd0, 7'd0, 32'h25, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 5'd0);
        rdy_in = 1'b0;
        alu_cdb_valid = 1'b1; alu_cdb_id = 5'd14; alu_cdb_val = 32'hAAAA;
        repeat (3) begin
            @(posedge clk_in);
            #1;
            chk("stall_have_ins", 32'(have_ins), 32'd0);
            chk("stall_ins_id", 32'(ins_id), 32'(last_id));
            chk("stall_rs1_val", rs1_val, last_rs1);
        end
        rdy_in = 1'b1; alu_cdb_valid = 1'b0;
        @(negedge clk_in); chk("resume_lat", 32'(have_ins), 32'd0);
        @(negedge clk_in); chk("resume_issue", 32'(have_ins), 32'd1);
        @(negedge clk_in); chk("stall_no_capture", 32'(have_ins), 32'd0);
        cycles(2);
        push_exp(5'd26, 32'h1414, 32'h2, 32'h0, 7'h33, 3'd1, 7'd0);
        bcast_alu(5'd14, 32'h1414);
        cycles(4);
        chk("stall_sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-operation: three waiting entries and an issue in flight
        for (int i = 0; i < 3; i++)
            dispatch(TAG_W'(27 + i), 7'h33, 3'd0, 7'd0, 32'h0, 1'b0, 32'h0, 5'd15, 1'b1, 32'h0, 5'd0);
        push_exp(5'd30, 32'h3, 32'h4, 32'h30, 7'h13, 3'd0, 7'd0);
        dispatch(5'd30, 7'h13, 3'd0, 7'd0, 32'h30, 1'b1, 32'h3, 5'd0, 1'b1, 32'h4, 5'd0);
        @(negedge clk_in);
        @(negedge clk_in); chk("pre_rst_issue", 32'(have_ins), 32'd1);
        #1 rst_in = 1'b0;
        #1;
        chk("mid_rst_have_ins", 32'(have_ins), 32'd0);
        chk("mid_rst_full", 32'(rs_full), 32'd0);
        chk("mid_rst_ins_id", 32'(ins_id), 32'd0);
        chk("mid_rst_imm", imm_val, 32'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        bcast_alu(5'd15, 32'h1515);
        cycles(6);
        chk("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("post_rst_have_ins", 32'(have_ins), 32'd0);
        chk("post_rst_full", 32'(rs_full), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
